// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC vectoring output stage: gain-compensation
// term tables, pre-rotation quadrant codes, FSM state type and binary-angle pi.
package cordic_pkg;

    localparam int CORDIC_GAIN_TERMS = 7;

    // 1/K ~= 0.6072540 as a signed sum of right-shifted copies of x.
    localparam int unsigned GAIN_SHIFT [CORDIC_GAIN_TERMS] = '{1, 3, 6, 9, 12, 14, 16};
    // Bit k set means term k is subtracted.
    localparam logic [CORDIC_GAIN_TERMS-1:0] GAIN_SUB = 7'b0011100;

    localparam logic [1:0] QUAD_NONE   = 2'b00;
    localparam logic [1:0] QUAD_ADD_PI = 2'b01;
    localparam logic [1:0] QUAD_SUB_PI = 2'b10;
    localparam logic [1:0] QUAD_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // +pi and -pi share one code in a binary angle of the given width.
    function automatic logic [31:0] angle_pi(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/cordic_gain_comp.sv
// Sequential shift-add removal of the CORDIC gain: one term per enabled cycle,
// o_done flags the cycle whose edge adds the final term.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_x,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_result
);

    localparam int ACC_W = DATA_WIDTH + 2;
    localparam logic [2:0] LAST_TERM = 3'(CORDIC_GAIN_TERMS - 1);

    logic [DATA_WIDTH-1:0]   r_x;
    logic signed [ACC_W-1:0] r_acc;
    logic [2:0]              r_k;

    int unsigned             w_shift;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W-1:0] w_acc_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_shift = GAIN_SHIFT[r_k];
        w_term  = '0;
        if (w_shift < DATA_WIDTH) begin
            w_term = $signed({2'b00, r_x >> w_shift});
        end
        w_acc_next = GAIN_SUB[r_k] ? (r_acc - w_term) : (r_acc + w_term);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_acc <= '0;
            r_k   <= '0;
        end else if (i_start) begin
            r_x   <= i_x;
            r_acc <= '0;
            r_k   <= '0;
        end else if (i_en) begin
            r_acc <= w_acc_next;
            r_k   <= (r_k == LAST_TERM) ? 3'd0 : r_k + 3'd1;
        end
    end

    assign o_done   = i_en && (r_k == LAST_TERM);
    assign o_result = w_acc_next[DATA_WIDTH-1:0];

endmodule

// File: rtl/cordic_vec_output_stage.sv
// CORDIC vectoring output stage: gain compensation, quadrant angle correction and
// valid/ready result hold. Gain compensation is built only with CORDIC_GAIN_COMP_EN.
module cordic_vec_output_stage
    import cordic_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ANGLE_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_x,
    input  logic [ANGLE_WIDTH-1:0] in_z,
    input  logic [1:0]             in_quad,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_mag,
    output logic [ANGLE_WIDTH-1:0] out_angle,
    output logic                   busy,
    output logic                   overrun
);

    localparam logic [ANGLE_WIDTH-1:0] ANGLE_PI = ANGLE_WIDTH'(angle_pi(ANGLE_WIDTH));

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_accept;
    logic [ANGLE_WIDTH-1:0] w_angle_corr;
    logic [DATA_WIDTH-1:0]  r_out_mag;
    logic [ANGLE_WIDTH-1:0] r_out_angle;
    logic                   r_overrun;

    assign w_accept = (r_state == ST_IDLE) && in_valid;

`ifdef CORDIC_GAIN_COMP_EN
    logic                  w_gc_done;
    logic [DATA_WIDTH-1:0] w_gc_result;

    cordic_gain_comp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_gain_comp (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept),
        .i_en     (r_state == ST_SCALE),
        .i_x      (in_x),
        .o_done   (w_gc_done),
        .o_result (w_gc_result)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
`ifdef CORDIC_GAIN_COMP_EN
                if (in_valid) w_state_next = ST_SCALE;
`else
                if (in_valid) w_state_next = ST_HOLD;
`endif
            end
`ifdef CORDIC_GAIN_COMP_EN
            ST_SCALE: if (w_gc_done) w_state_next = ST_HOLD;
`endif
            ST_HOLD:  if (out_ready) w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_HOLD);
        busy      = (r_state != ST_IDLE);
    end

    // Code 11 is reserved and passes the angle through like 00.
    always_comb begin
        w_angle_corr = in_z;
        if (in_quad == QUAD_ADD_PI || in_quad == QUAD_SUB_PI) begin
            w_angle_corr = in_z + ANGLE_PI;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_mag   <= '0;
            r_out_angle <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_accept) r_out_angle <= w_angle_corr;
`ifdef CORDIC_GAIN_COMP_EN
            if (r_state == ST_SCALE && w_gc_done) r_out_mag <= w_gc_result;
`else
            if (w_accept) r_out_mag <= in_x;
`endif
            if (in_valid && r_state != ST_IDLE) r_overrun <= 1'b1;
        end
    end

    assign out_mag   = r_out_mag;
    assign out_angle = r_out_angle;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_cordic_vec_output_stage.sv
// Scoreboard bench for cordic_vec_output_stage; expectations follow CORDIC_GAIN_COMP_EN.
module tb_cordic_vec_output_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_z;
    logic [1:0]  in_quad;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_mag;
    logic [15:0] out_angle;
    logic        busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] mag_q[$];
    logic [15:0] ang_q[$];

`ifdef CORDIC_GAIN_COMP_EN
    localparam int          LAT_EDGES = 8;   // accept edge plus seven term edges
    localparam logic [15:0] MAG_4000  = 16'd9949;
    localparam logic [15:0] MAG_FFFF  = 16'd39796;
`else
    localparam int          LAT_EDGES = 1;
    localparam logic [15:0] MAG_4000  = 16'h4000;
    localparam logic [15:0] MAG_FFFF  = 16'hFFFF;
`endif

    cordic_vec_output_stage #(
        .DATA_WIDTH  (16),
        .ANGLE_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_z      (in_z),
        .in_quad   (in_quad),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mag   (out_mag),
        .out_angle (out_angle),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mag_model(input logic [15:0] x);
`ifdef CORDIC_GAIN_COMP_EN
        int sh [7] = '{1, 3, 6, 9, 12, 14, 16};
        bit neg [7] = '{0, 0, 1, 1, 1, 0, 0};
        int acc = 0;
        int t;
        for (int k = 0; k < 7; k++) begin
            t = (sh[k] >= 16) ? 0 : (int'(x) >> sh[k]);
            acc = neg[k] ? acc - t : acc + t;
        end
        return 16'(acc);
`else
        return x;
`endif
    endfunction

    function automatic logic [15:0] angle_model(input logic [15:0] z, input logic [1:0] q);
        return (q == 2'b01 || q == 2'b10) ? z + 16'h8000 : z;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b1);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_out_mag"},   out_mag,   16'h0);
        check({tag, "_out_angle"}, out_angle, 16'h0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_overrun"},   overrun,   1'b0);
    endtask

    // One transaction: push expectations, measure latency, hold for `stall`
    // cycles (optionally poking in_valid mid-hold), then release.
    task automatic run_txn(input logic [15:0] x, input logic [15:0] z, input logic [1:0] q,
                           input logic [15:0] exp_mag, input logic [15:0] exp_ang,
                           input int stall, input bit poke);
        int n;
        logic [15:0] em;
        logic [15:0] ea;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_x = x;
        in_z = z;
        in_quad = q;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        mag_q.push_back(exp_mag);
        ang_q.push_back(exp_ang);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT_EDGES);
        em = mag_q.pop_front();
        ea = ang_q.pop_front();
        check("out_mag", out_mag, em);
        check("out_angle", out_angle, ea);
        check("busy_hold", busy, 1'b1);
        for (int i = 0; i < stall; i++) begin
            if (poke && i == stall / 2) begin
                in_x = ~x;
                in_z = ~z;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("hold_valid", out_valid, 1'b1);
            check("hold_mag", out_mag, em);
            check("hold_angle", out_angle, ea);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", out_valid, 1'b0);
        check("ready_back", in_ready, 1'b1);
    endtask

    initial begin
        logic [15:0] rx;
        logic [15:0] rz;
        logic [1:0]  rq;

        rst = 1'b0;
        in_valid = 1'b0;
        in_x = '0;
        in_z = '0;
        in_quad = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b1;
        @(negedge clk);

        run_txn(16'h4000, 16'h2000, 2'b00, MAG_4000, 16'h2000, 0, 1'b0);
        check("overrun_clean", overrun, 1'b0);
        run_txn(16'h2000, 16'h2000, 2'b01, mag_model(16'h2000), 16'hA000, 1, 1'b0);
        run_txn(16'h0123, 16'hE000, 2'b10, mag_model(16'h0123), 16'h6000, 2, 1'b0);
        run_txn(16'h8001, 16'h1234, 2'b11, mag_model(16'h8001), 16'h1234, 0, 1'b0);

        // Long stall with an in_valid pulse during HOLD.
        run_txn(16'h7FFF, 16'h3000, 2'b00, mag_model(16'h7FFF), 16'h3000, 20, 1'b1);
        check("overrun_set", overrun, 1'b1);
        run_txn(16'h0001, 16'h4000, 2'b01, mag_model(16'h0001), 16'hC000, 0, 1'b0);
        check("overrun_sticky", overrun, 1'b1);

        // Reset three terms into SCALE (HOLD when compensation is absent).
        in_x = 16'h5555;
        in_z = 16'h1111;
        in_quad = 2'b01;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        run_txn(16'hFFFF, 16'h0000, 2'b00, MAG_FFFF, 16'h0000, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rx = 16'($urandom);
            rz = 16'($urandom);
            rq = 2'($urandom_range(0, 3));
            run_txn(rx, rz, rq, mag_model(rx), angle_model(rz, rq), $urandom_range(0, 3), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
